// File: rtl/register_dump_reader.sv
// Walks a register range through the register file's debug port and streams each
// value as a 5-byte record {3'b100, idx}, data[31:24] .. data[7:0] on a valid/ready byte link.
module register_dump_reader (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  first_reg,
    input  logic [4:0]  last_reg,
    output logic [4:0]  read_address_debug,
    output logic        clock_debug,
    input  logic [31:0] data_in_debug,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ADDR   = 3'd1;
    localparam logic [2:0] STROBE = 3'd2;
    localparam logic [2:0] SETTLE = 3'd3;
    localparam logic [2:0] SEND   = 3'd4;

    logic [2:0]  state;
    logic [4:0]  idx;
    logic [4:0]  last_idx;
    logic [2:0]  byte_count;
    logic [31:0] shift_reg;
    logic        accept;
    logic        record_end;
    logic        range_end;

    assign accept     = tx_valid & tx_ready;
    assign record_end = (byte_count == 3'd4);
    assign range_end  = (idx == last_idx);

    // The capture step is the SETTLE exit edge: data is taken and the header is
    // presented in the same edge, which keeps the per-register overhead at 3 cycles.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state              <= IDLE;
            idx                <= 5'd0;
            last_idx           <= 5'd0;
            byte_count         <= 3'd0;
            shift_reg          <= 32'd0;
            read_address_debug <= 5'd0;
            clock_debug        <= 1'b0;
            tx_data            <= 8'd0;
            tx_valid           <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx                <= first_reg;
                        last_idx           <= last_reg;
                        read_address_debug <= first_reg;
                        busy               <= 1'b1;
                        state              <= ADDR;
                    end
                end
                ADDR: begin
                    clock_debug <= 1'b1;
                    state       <= STROBE;
                end
                STROBE: begin
                    clock_debug <= 1'b0;
                    state       <= SETTLE;
                end
                SETTLE: begin
                    shift_reg  <= data_in_debug;
                    tx_data    <= {3'b100, idx};
                    tx_valid   <= 1'b1;
                    byte_count <= 3'd0;
                    state      <= SEND;
                end
                SEND: begin
                    if (accept) begin
                        if (record_end) begin
                            tx_valid   <= 1'b0;
                            byte_count <= 3'd0;
                            if (range_end) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                idx                <= idx + 5'd1;
                                read_address_debug <= idx + 5'd1;
                                state              <= ADDR;
                            end
                        end else begin
                            // Data bytes leave MSB first out of the top of the shifter.
                            tx_data    <= shift_reg[31:24];
                            shift_reg  <= {shift_reg[23:0], 8'h00};
                            byte_count <= byte_count + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_dump_reader.sv
// Randomized bench for register_dump_reader: a register-file model answers debug strobes,
// and every dump is compared with a byte stream built directly from the range rules.
module tb_register_dump_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  first_reg = 5'd0;
    logic [4:0]  last_reg = 5'd0;
    logic [4:0]  read_address_debug;
    logic        clock_debug;
    logic [31:0] data_in_debug;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        done;

    register_dump_reader dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .first_reg          (first_reg),
        .last_reg           (last_reg),
        .read_address_debug (read_address_debug),
        .clock_debug        (clock_debug),
        .data_in_debug      (data_in_debug),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .busy               (busy),
        .done               (done)
    );

    always #5 clock = ~clock;

    // Register file model: captures the addressed register on the debug strobe rise
    logic [31:0] regs [32];
    logic [31:0] regData = 32'd0;
    assign data_in_debug = regData;
    always @(posedge clock_debug) regData <= regs[read_address_debug];

    int cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    int checks = 0;
    int errors = 0;
    int startCycle = 0;
    int readyMode = 0;
    int stallFrom = 0;

    logic [7:0] gotBytes[$];
    logic [4:0] gotAddrs[$];
    logic [7:0] expBytes[$];
    logic [4:0] expAddrs[$];
    int doneCount = 0;
    int doneCycle = 0;
    int firstValidCycle = -1;
    int protocolErrs = 0;

    logic       prevClockDebug = 1'b0;
    logic       prevValid = 1'b0;
    logic       prevReady = 1'b0;
    logic [4:0] prevAddr = 5'd0;
    logic [7:0] prevData = 8'd0;

    // Link monitor plus strobe/handshake protocol watcher
    always @(negedge clock) begin
        if (reset) begin
            if (tx_valid && tx_ready) gotBytes.push_back(tx_data);
            if (tx_valid && firstValidCycle < 0) firstValidCycle = cycle;
            if (clock_debug) begin
                gotAddrs.push_back(read_address_debug);
                if (prevClockDebug || read_address_debug != prevAddr) protocolErrs++;
            end
            if (prevClockDebug && read_address_debug != prevAddr) protocolErrs++;
            if (prevValid && !prevReady && (!tx_valid || tx_data != prevData)) protocolErrs++;
            if (done) begin
                doneCount++;
                doneCycle = cycle;
            end
        end
        prevClockDebug = clock_debug;
        prevValid      = tx_valid;
        prevReady      = tx_ready;
        prevAddr       = read_address_debug;
        prevData       = tx_data;
    end

    // Transmitter model: always ready, random, or a 10-cycle stall then random
    initial begin
        forever begin
            @(posedge clock);
            #2;
            case (readyMode)
                0: tx_ready = 1'b1;
                1: tx_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (cycle >= stallFrom && cycle < stallFrom + 10) tx_ready = 1'b0;
                    else tx_ready = 1'($urandom_range(0, 1));
                end
            endcase
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int f, input int l);
        @(posedge clock);
        #1;
        first_reg = 5'(f);
        last_reg  = 5'(l);
        start     = 1'b1;
        @(posedge clock);
        #1;
        start      = 1'b0;
        startCycle = cycle;
    endtask

    // Reference stream straight from the record format and modular range rule
    function automatic int buildExpected(input int f, input int l);
        int n;
        logic [31:0] v;
        expBytes.delete();
        expAddrs.delete();
        n = (((l - f) % 32) + 32) % 32 + 1;
        for (int k = 0; k < n; k++) begin
            int i;
            i = (f + k) % 32;
            v = regs[i];
            expAddrs.push_back(5'(i));
            expBytes.push_back(8'(8'h80 + i));
            for (int b = 3; b >= 0; b--) expBytes.push_back(v[8*b +: 8]);
        end
        return n;
    endfunction

    task automatic clearMonitor();
        gotBytes.delete();
        gotAddrs.delete();
        doneCount       = 0;
        doneCycle       = 0;
        firstValidCycle = -1;
        protocolErrs    = 0;
    endtask

    task automatic runDump(input string name, input int f, input int l, input int mode, input bit midStart);
        int n;
        logic [31:0] gv;
        n = buildExpected(f, l);
        readyMode = mode;
        clearMonitor();
        applyStimulus(f, l);
        stallFrom = startCycle + 5;
        checkOutput({name, " busy after start"}, 32'(busy), 32'd1);
        checkOutput({name, " first address"}, 32'(read_address_debug), 32'(f));
        if (midStart) begin
            repeat (10) @(posedge clock);
            #1;
            first_reg = 5'(f + 13);
            last_reg  = 5'(f + 14);
            start     = 1'b1;
            @(posedge clock);
            #1;
            start = 1'b0;
        end
        for (int i = 0; i < 8 * n * 6 + 100; i++) begin
            @(negedge clock);
            #1;
            if (doneCount > 0) break;
        end
        if (doneCount == 0) checkOutput({name, " done timeout"}, 32'd0, 32'd1);
        repeat (4) @(negedge clock);
        #1;
        checkOutput({name, " byte count"}, 32'(gotBytes.size()), 32'(expBytes.size()));
        for (int k = 0; k < expBytes.size(); k++) begin
            gv = (k < gotBytes.size()) ? 32'(gotBytes[k]) : 32'hFFFF_FFFF;
            checkOutput($sformatf("%s byte %0d", name, k), gv, 32'(expBytes[k]));
        end
        checkOutput({name, " strobe count"}, 32'(gotAddrs.size()), 32'(expAddrs.size()));
        for (int k = 0; k < expAddrs.size(); k++) begin
            gv = (k < gotAddrs.size()) ? 32'(gotAddrs[k]) : 32'hFFFF_FFFF;
            checkOutput($sformatf("%s strobe addr %0d", name, k), gv, 32'(expAddrs[k]));
        end
        checkOutput({name, " protocol violations"}, 32'(protocolErrs), 32'd0);
        checkOutput({name, " done pulses"}, 32'(doneCount), 32'd1);
        checkOutput({name, " busy at end"}, 32'(busy), 32'd0);
        if (mode == 0) begin
            checkOutput({name, " header latency"}, 32'(firstValidCycle - startCycle), 32'd3);
            checkOutput({name, " done latency"}, 32'(doneCycle - startCycle), 32'(8 * n));
        end
        readyMode = 0;
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, " read_address_debug"}, 32'(read_address_debug), 32'd0);
        checkOutput({name, " clock_debug"}, 32'(clock_debug), 32'd0);
        checkOutput({name, " tx_data"}, 32'(tx_data), 32'd0);
        checkOutput({name, " tx_valid"}, 32'(tx_valid), 32'd0);
        checkOutput({name, " busy"}, 32'(busy), 32'd0);
        checkOutput({name, " done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int f;
        int l;
        for (int i = 0; i < 32; i++) regs[i] = {4{8'(i)}};

        $display("[TB] reset");
        repeat (3) @(posedge clock);
        #1;
        checkResetOutputs("reset");
        reset = 1'b1;

        $display("[TB] single register");
        regs[3] = 32'hDEADBEEF;
        runDump("single", 3, 3, 0, 1'b0);
        regs[3] = 32'h03030303;

        $display("[TB] full dump");
        runDump("full", 0, 31, 0, 1'b0);

        $display("[TB] wrap-around");
        runDump("wrap", 30, 1, 0, 1'b0);

        $display("[TB] backpressure");
        runDump("stall", 0, 31, 2, 1'b0);

        $display("[TB] start while busy");
        runDump("busy start", 5, 9, 0, 1'b1);

        $display("[TB] reset mid-record");
        readyMode = 0;
        clearMonitor();
        applyStimulus(7, 10);
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            #1;
            if (gotBytes.size() >= 7) break;
        end
        checkOutput("midreset reached byte 7", 32'(gotBytes.size() >= 7), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkResetOutputs("midreset");
        reset = 1'b1;
        clearMonitor();
        repeat (20) @(posedge clock);
        #1;
        checkOutput("midreset trailing bytes", 32'(gotBytes.size()), 32'd0);
        checkOutput("midreset trailing strobes", 32'(gotAddrs.size()), 32'd0);
        runDump("after reset", 7, 10, 0, 1'b0);

        $display("[TB] random dumps");
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            f = $urandom_range(0, 31);
            l = $urandom_range(0, 31);
            runDump($sformatf("random%0d", t), f, l, (t % 2 == 0) ? 1 : 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_dump_reader.md
# register_dump_reader

Debug-side reader for the CPU register file's debug port. On a start pulse it walks a selected register range and strobes the file's debug clock for each register. It captures each 32-bit value and serializes it as a 5-byte record on a valid/ready byte stream that feeds the board UART transmitter. It sits between the register file's debug read port and the debug serial link, and never touches the architectural read/write ports.

## Interface
- No parameters. Register count (32) and data width (32) are fixed to match the register file.
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- start  in  1  begin a dump; sampled only while busy=0.
- first_reg  in  5  first register index; latched when start is accepted.
- last_reg  in  5  last register index; latched when start is accepted.
- read_address_debug  out  5  debug read address to the register file.
- clock_debug  out  1  registered one-cycle strobe; the register file captures on its rising edge.
- data_in_debug  in  32  register value returned by the register file's debug output.
- tx_data  out  8  byte to transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts the byte when tx_valid=1 and tx_ready=1 at a rising edge.
- busy  out  1  dump in progress.
- done  out  1  one-cycle pulse after the final byte of a dump is accepted.

## Operation
- Record per register: header byte {3'b100, idx}, then data bytes [31:24], [23:16], [15:8], [7:0] (MSB first).
- Range walk:
  - Start at first_reg, increment modulo 32, stop after last_reg is sent.
  - Register count = ((last_reg - first_reg) mod 32) + 1.
  - first_reg == last_reg gives one register; first_reg = last_reg + 1 (mod 32) gives all 32.
- FSM states:
  - IDLE: start=1 latches the range, sets idx=first_reg and busy=1, then goes to ADDR.
  - ADDR: read_address_debug=idx, clock_debug=0.
  - STROBE: clock_debug=1, address held.
  - SETTLE: clock_debug=0, address held.
  - CAPTURE: loads data_in_debug into a 32-bit shift register, presents the header, sets tx_valid=1, then goes to SEND.
  - SEND: holds tx_valid. Each accepted byte advances a 3-bit byte counter (0..4).
    - On acceptance of byte 4 with idx==last_reg: go to IDLE, busy=0, done=1 for one cycle.
    - Otherwise: idx=idx+1 (mod 32), go to ADDR.
- Handshake:
  - tx_data stays stable while tx_valid=1 and tx_ready=0.
  - tx_valid never drops before acceptance.
  - No byte is skipped or repeated.
- start while busy=1 is ignored and has no side effects. start in the cycle done=1 is accepted.
- Reset mid-operation returns the block to IDLE at the next edge and discards any partial record. No trailing bytes are emitted.
- Reset values: read_address_debug=0, clock_debug=0, tx_data=0, tx_valid=0, busy=0, done=0. Internal idx, byte counter and shift register are also 0.

## Timing
- start sampled at edge E:
  - after E: ADDR (busy=1)
  - after E+1: clock_debug=1
  - after E+2: clock_debug=0
  - after E+3: tx_valid=1 with header
- read_address_debug is stable at least one full cycle before the clock_debug rise and until CAPTURE.
- data_in_debug is sampled two edges after the strobe rise.
- With tx_ready held at 1:
  - one byte per cycle
  - 5 cycles in SEND per register plus 3 overhead cycles, so 8 cycles per register
  - full 32-register dump: 256 cycles from start to done
- Last byte accepted at edge F: done=1 and busy=0 after F. Otherwise the next ADDR follows F, and the next header appears after F+3.
- clock_debug is high for exactly one cycle per register, never two consecutive cycles.

## Test plan
- Single register: reg3=0xDEADBEEF, first=last=3, tx_ready=1 → bytes 0x83,0xDE,0xAD,0xBE,0xEF on consecutive cycles starting 3 cycles after start; exactly one clock_debug pulse (address=3); done pulses once 8 cycles after start.
- Full dump: reg i = {4{i[7:0]}} (e.g. reg 5 = 0x05050505), first=0, last=31 → 160 bytes in index order, headers 0x80..0x9F, 32 strobes, done at cycle 256; reg0 reads 0.
- Wrap-around: first=30, last=1 → headers 0x9E, 0x9F, 0x80, 0x81, 20 bytes total, then done.
- Backpressure: tx_ready low for 10 cycles mid-record, then random toggling → tx_data/tx_valid held while stalled; byte sequence identical to the tx_ready=1 run.
- Control: start pulsed while busy → ignored, range unchanged. reset driven low after 2 bytes of a record → next cycle all outputs at reset values. A subsequent start dumps cleanly from first_reg.
- Strobe protocol: checker asserts address stable from one cycle before each clock_debug rise through CAPTURE, and that clock_debug is never high for 2 cycles.
